// File: rtl/alu_rv_pipe.sv
// Two-stage ready/valid ALU: operand capture register, combinational compute,
// and a circular result FIFO whose free space is granted to upstream as credit.
module alu_rv_pipe #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic                          i_VALID,
  output logic                          o_READY,
  input  logic [WIDTH-1:0]              i_A,
  input  logic [WIDTH-1:0]              i_B,
  input  logic [1:0]                    i_SEL,
  output logic                          o_VALID,
  input  logic                          i_READY,
  output logic [WIDTH-1:0]              o_Y,
  output logic                          o_OVF,
  output logic                          o_ERR,
  output logic [$clog2(FIFO_DEPTH):0]   o_LEVEL
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int SW  = 2 * WIDTH;
  localparam int CW  = $clog2(SW + 1);
  // Counter/position width is at least WIDTH+1 so the overflow slice always exists.
  localparam int CWX = (CW > WIDTH) ? CW : WIDTH + 1;
  localparam logic [LW:0] DEPTH_C = (LW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OP_SUB    = 2'b00,
    OP_NAND   = 2'b01,
    OP_LONES  = 2'b10,
    OP_ONEHOT = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             err;
  } res_t;

  // Stage-1 operand register
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;

  // Output FIFO
  res_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic [LW-1:0]    count_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic [LW:0]      occupancy;
  res_t             s2_res;
  res_t             head;

  // Credit is computed from registered state only, so o_READY never depends on
  // i_READY or i_VALID. With FIFO_DEPTH=2 the credit loop sustains 2 results
  // every 3 cycles; a depth of 4 or more sustains one per cycle.
  assign occupancy = {{LW{1'b0}}, s1_valid_q} + {1'b0, count_q};
  assign o_READY   = (occupancy < DEPTH_C);
  assign accept    = i_VALID & o_READY;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_SUB;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q  <= i_A;
        s1_b_q  <= i_B;
        s1_op_q <= op_e'(i_SEL);
      end
    end
  end

  logic [SW-1:0]    cat;
  logic [WIDTH-1:0] diff;
  logic [CWX-1:0]   ones_cnt;
  logic [CWX-1:0]   hot_pos;
  logic             ones_run;
  logic             hot_seen;
  logic             hot_multi;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cat       = {s1_b_q, s1_a_q};
    diff      = s1_a_q - s1_b_q;
    ones_cnt  = '0;
    ones_run  = 1'b1;
    hot_pos   = '0;
    hot_seen  = 1'b0;
    hot_multi = 1'b0;
    s2_res    = '0;

    for (int i = SW - 1; i >= 0; i--) begin
      if (ones_run && cat[i]) ones_cnt = ones_cnt + CWX'(1);
      else                    ones_run = 1'b0;
    end

    for (int i = 0; i < SW; i++) begin
      if (cat[i]) begin
        if (hot_seen) hot_multi = 1'b1;
        hot_seen = 1'b1;
        hot_pos  = CWX'(i);
      end
    end

    case (s1_op_q)
      OP_SUB: begin
        s2_res.y   = diff;
        s2_res.ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                     (diff[WIDTH-1]   != s1_a_q[WIDTH-1]);
      end
      OP_NAND: begin
        s2_res.y = ~(s1_a_q & s1_b_q);
      end
      OP_LONES: begin
        s2_res.y   = ones_cnt[WIDTH-1:0];
        s2_res.ovf = |ones_cnt[CWX-1:WIDTH];
      end
      OP_ONEHOT: begin
        if (!hot_seen || hot_multi) begin
          s2_res.err = 1'b1;
        end else begin
          s2_res.y   = hot_pos[WIDTH-1:0];
          s2_res.ovf = |hot_pos[CWX-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  // Stage 1 drains into the FIFO every cycle; credit guarantees room for it.
  assign push    = s1_valid_q;
  assign o_VALID = (count_q != '0);
  assign pop     = o_VALID & i_READY;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was written, and the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge i_CLK) begin
    if (push) mem_q[wr_ptr_q] <= s2_res;
  end

  assign head    = mem_q[rd_ptr_q];
  assign o_Y     = o_VALID ? head.y   : '0;
  assign o_OVF   = o_VALID ? head.ovf : 1'b0;
  assign o_ERR   = o_VALID ? head.err : 1'b0;
  assign o_LEVEL = count_q;

endmodule

// File: tb/tb_alu_rv_pipe.sv
// Scoreboard bench for alu_rv_pipe: the driver queues expected results on
// accept, an independent monitor compares the FIFO head whenever o_VALID is high.
module tb_alu_rv_pipe;

  localparam int W = 4;
  localparam int D = 2;

  typedef struct packed {
    logic [W-1:0] y;
    logic         ovf;
    logic         err;
  } res_t;

  logic                 i_CLK;
  logic                 i_RSTn;
  logic                 i_VALID;
  logic                 o_READY;
  logic [W-1:0]         i_A;
  logic [W-1:0]         i_B;
  logic [1:0]           i_SEL;
  logic                 o_VALID;
  logic                 i_READY;
  logic [W-1:0]         o_Y;
  logic                 o_OVF;
  logic                 o_ERR;
  logic [$clog2(D):0]   o_LEVEL;

  int   n_checks = 0;
  int   n_errors = 0;
  int   pops     = 0;
  res_t exp_q[$];

  alu_rv_pipe #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .i_CLK   (i_CLK),
    .i_RSTn  (i_RSTn),
    .i_VALID (i_VALID),
    .o_READY (o_READY),
    .i_A     (i_A),
    .i_B     (i_B),
    .i_SEL   (i_SEL),
    .o_VALID (o_VALID),
    .i_READY (i_READY),
    .o_Y     (o_Y),
    .o_OVF   (o_OVF),
    .o_ERR   (o_ERR),
    .o_LEVEL (o_LEVEL)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: signed arithmetic and integer bit scans over {B,A}.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] sel);
    res_t r;
    int   sa, sb, d, v, n, pos;
    r  = '0;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    v  = int'(b) * (1 << W) + int'(a);
    case (sel)
      2'd0: begin
        d     = sa - sb;
        r.y   = W'((int'(a) - int'(b)) & ((1 << W) - 1));
        r.ovf = (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
      end
      2'd1: r.y = ~(a & b);
      2'd2: begin
        n = 0;
        while (n < 2 * W && v[2 * W - 1 - n]) n++;
        r.y   = W'(n % (1 << W));
        r.ovf = (n > (1 << W) - 1);
      end
      default: begin
        if ($countones(v) == 1) begin
          pos   = $clog2(v);
          r.y   = W'(pos % (1 << W));
          r.ovf = (pos > (1 << W) - 1);
        end else begin
          r.err = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  // Called at a falling edge; holds the request until accepted, returns at a falling edge.
  task automatic drive_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] sel, input res_t e);
    int guard = 0;
    i_VALID = 1'b1;
    i_A     = a;
    i_B     = b;
    i_SEL   = sel;
    #1;
    while (!o_READY && guard < 64) begin
      @(negedge i_CLK);
      #1;
      guard++;
    end
    check("accept_ready", {31'b0, o_READY}, 32'd1);
    if (o_READY) exp_q.push_back(e);
    @(negedge i_CLK);
    i_VALID = 1'b0;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
    drive_exp(a, b, sel, model(a, b, sel));
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge i_CLK);
      guard++;
    end
    #3;
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_no_valid", {31'b0, o_VALID}, 32'd0);
  endtask

  // Monitor: the head must always equal the oldest outstanding expectation.
  always @(negedge i_CLK) begin
    #2;
    if (i_RSTn && o_VALID) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, o_VALID}, 32'd0);
      end else begin
        check("result", {26'b0, o_Y, o_OVF, o_ERR}, {26'b0, exp_q[0]});
        if (i_READY) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    i_RSTn  = 1'b0;
    i_VALID = 1'b0;
    i_A     = '0;
    i_B     = '0;
    i_SEL   = '0;
    i_READY = 1'b1;

    @(negedge i_CLK);
    #1;
    check("rst_valid", {31'b0, o_VALID}, 32'd0);
    check("rst_y",     {28'b0, o_Y},     32'd0);
    check("rst_ovf",   {31'b0, o_OVF},   32'd0);
    check("rst_err",   {31'b0, o_ERR},   32'd0);
    check("rst_level", {30'b0, o_LEVEL}, 32'd0);
    check("rst_ready", {31'b0, o_READY}, 32'd1);
    i_RSTn = 1'b1;
    @(negedge i_CLK);

    // First result: o_VALID low one edge after accept, high after the second.
    drive_exp(4'h5, 4'hC, 2'd0, res_t'{4'h9, 1'b1, 1'b0});
    #1;
    check("lat_not_yet", {31'b0, o_VALID}, 32'd0);
    @(negedge i_CLK);
    #1;
    check("lat_valid", {31'b0, o_VALID}, 32'd1);
    check("lat_level", {30'b0, o_LEVEL}, 32'd1);
    @(negedge i_CLK);

    drive_exp(4'h3, 4'h1, 2'd0, res_t'{4'h2, 1'b0, 1'b0});
    drive_exp(4'hC, 4'hA, 2'd1, res_t'{4'h7, 1'b0, 1'b0});
    drive_exp(4'hC, 4'hF, 2'd2, res_t'{4'h6, 1'b0, 1'b0});
    drive_exp(4'hC, 4'h7, 2'd2, res_t'{4'h0, 1'b0, 1'b0});
    drive_exp(4'h4, 4'h0, 2'd3, res_t'{4'h2, 1'b0, 1'b0});
    drive_exp(4'h0, 4'h8, 2'd3, res_t'{4'h7, 1'b0, 1'b0});
    drive_exp(4'h0, 4'h1, 2'd3, res_t'{4'h4, 1'b0, 1'b0});
    drive_exp(4'h5, 4'h0, 2'd3, res_t'{4'h0, 1'b0, 1'b1});
    drive_exp(4'h0, 4'h0, 2'd3, res_t'{4'h0, 1'b0, 1'b1});
    drive_exp(4'hF, 4'hF, 2'd2, res_t'{4'h8, 1'b0, 1'b0});
    drain();

    // Backpressure: three requests with the consumer stalled.
    @(negedge i_CLK);
    i_READY = 1'b0;
    p0 = pops;
    drive_exp(4'hC, 4'hA, 2'd1, res_t'{4'h7, 1'b0, 1'b0});
    drive_exp(4'hC, 4'hF, 2'd2, res_t'{4'h6, 1'b0, 1'b0});
    i_VALID = 1'b1;
    i_A     = 4'h0;
    i_B     = 4'h7;
    i_SEL   = 2'd2;
    #1;
    check("bp_ready_low", {31'b0, o_READY}, 32'd0);
    check("bp_accepted", exp_q.size(), 32'd2);
    @(negedge i_CLK);
    #1;
    check("bp_level_full", {30'b0, o_LEVEL}, 32'd2);
    check("bp_still_low", {31'b0, o_READY}, 32'd0);
    @(negedge i_CLK);
    i_READY = 1'b1;
    drive_exp(4'h0, 4'h7, 2'd2, res_t'{4'h0, 1'b0, 1'b0});
    drain();
    check("bp_pops", pops - p0, 32'd3);

    // Streaming burst of 8.
    @(negedge i_CLK);
    p0 = pops;
    for (int k = 0; k < 8; k++) begin
      drive(W'($urandom), W'($urandom), 2'($urandom));
    end
    drain();
    check("stream_pops", pops - p0, 32'd8);

    // Reset with the FIFO full.
    @(negedge i_CLK);
    i_READY = 1'b0;
    drive(4'h9, 4'h2, 2'd0);
    drive(4'h6, 4'h3, 2'd1);
    @(negedge i_CLK);
    #1;
    check("rst_pre_level", {30'b0, o_LEVEL}, 32'd2);
    #2;
    i_RSTn = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", {31'b0, o_VALID}, 32'd0);
    check("midrst_level", {30'b0, o_LEVEL}, 32'd0);
    check("midrst_ready", {31'b0, o_READY}, 32'd1);
    i_RSTn = 1'b1;
    @(negedge i_CLK);
    i_READY = 1'b1;
    p0 = pops;
    drive_exp(4'h3, 4'h1, 2'd0, res_t'{4'h2, 1'b0, 1'b0});
    drain();
    check("postrst_pops", pops - p0, 32'd1);

    // Random traffic with random consumer stalls.
    @(negedge i_CLK);
    for (int k = 0; k < 400; k++) begin
      i_READY = 1'($urandom_range(0, 1));
      i_VALID = 1'($urandom_range(0, 1));
      i_A     = W'($urandom);
      i_B     = W'($urandom);
      i_SEL   = 2'($urandom);
      #1;
      if (i_VALID && o_READY) exp_q.push_back(model(i_A, i_B, i_SEL));
      @(negedge i_CLK);
    end
    i_VALID = 1'b0;
    i_READY = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
